lfsr_burst_ctrl: RTL

Two-requester scheduler that shares one 4-bit maximal-length Fibonacci LFSR between two command ports. It arbitrates round-robin, optionally reseeds the LFSR, and streams a burst of LFSR words to a single valid/ready output. The output is tagged with the owning requester. It sits between the test-pattern/scrambler clients and the shared pseudo-random source.

---
 rtl/lfsr_burst_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lfsr_burst_ctrl.sv
// rtl/lfsr_burst_ctrl.sv - two-requester round-robin burst scheduler over a shared 4-bit LFSR
module lfsr_burst_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cmd_valid,
  output logic [1:0]       cmd_ready,
  input  logic [3:0]       cmd0_seed,
  input  logic [3:0]       cmd1_seed,
  input  logic             cmd0_reseed,
  input  logic             cmd1_reseed,
  input  logic [CNT_W-1:0] cmd0_len,
  input  logic [CNT_W-1:0] cmd1_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_id,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             lockup_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       lfsr_q, lfsr_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             id_q, id_d;
  logic             done_q, done_d;
  logic             lockup_q, lockup_d;

  logic [1:0]       grant;
  logic             sel;
  logic [3:0]       sel_seed;
  logic             sel_reseed;
  logic [CNT_W-1:0] sel_len;

  // x^4+x^3+1 Fibonacci step
  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // Pointer only matters when both request; a lone requester always wins.
  assign grant[0]   = cmd_valid[0] & (~cmd_valid[1] | ~rr_q);
  assign grant[1]   = cmd_valid[1] & (~cmd_valid[0] | rr_q);
  assign sel        = grant[1];
  assign sel_seed   = sel ? cmd1_seed   : cmd0_seed;
  assign sel_reseed = sel ? cmd1_reseed : cmd0_reseed;
  assign sel_len    = sel ? cmd1_len    : cmd0_len;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    rr_d      = rr_q;
    rem_d     = rem_q;
    id_d      = id_q;
    done_d    = 1'b0;
    lockup_d  = 1'b0;
    cmd_ready = 2'b00;
    case (state_q)
      IDLE: begin
        cmd_ready = reset ? 2'b00 : grant;
        if (|cmd_ready) begin
          rr_d  = ~sel;
          id_d  = sel;
          rem_d = sel_len;
          if (sel_reseed) begin
            if (sel_seed == 4'h0) begin
              lfsr_d   = 4'h1;
              lockup_d = 1'b1;
            end else begin
              lfsr_d = sel_seed;
            end
          end
          if (sel_len != '0) begin
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          lfsr_d = lfsr_step(lfsr_q);
          rem_d  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= 4'h1;
      rr_q     <= 1'b0;
      rem_q    <= '0;
      id_q     <= 1'b0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      rr_q     <= rr_d;
      rem_q    <= rem_d;
      id_q     <= id_d;
      done_q   <= done_d;
      lockup_q <= lockup_d;
    end
  end

  assign out_valid  = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign out_data   = lfsr_q;
  assign out_id     = id_q;
  assign out_last   = (state_q == RUN) && (rem_q == CNT_W'(1));
  assign done       = done_q;
  assign lockup_err = lockup_q;

endmodule
